// File: rtl/tof_pkg.sv
// Shared definitions for the time-of-flight echo timer: FSM encoding,
// register addresses, bit positions and the unmapped-read pattern.
package tof_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_CONTROL = 3'd0;
    localparam logic [2:0] ADDR_STATUS  = 3'd1;
    localparam logic [2:0] ADDR_TIMEOUT = 3'd2;
    localparam logic [2:0] ADDR_BLANK   = 3'd3;

    localparam int CTRL_ARM_BIT    = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_ABORT_BIT  = 2;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_TIMEOUT_BIT = 2;
    localparam int STAT_COUNT_LSB   = 4;

    localparam logic [31:0] UNMAPPED_RDATA = 32'h89AB_CDEF;

    function automatic logic [31:0] pack_status(input logic       busy,
                                                input logic       done,
                                                input logic       tflag,
                                                input logic [2:0] cnt);
        logic [31:0] s;
        s = '0;
        s[STAT_BUSY_BIT]                      = busy;
        s[STAT_DONE_BIT]                      = done;
        s[STAT_TIMEOUT_BIT]                   = tflag;
        s[STAT_COUNT_LSB+2:STAT_COUNT_LSB]    = cnt;
        return s;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector producing a
// one-cycle pulse in the clk domain.
module sync_edge (
    input  logic clk,
    input  logic srst,
    input  logic async_in,
    output logic pulse
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= async_in;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign pulse = sync_reg & ~prev_reg;

endmodule

// File: rtl/tof_echo_timer.sv
// Laser time-of-flight echo timer: counts cycles from the laser strobe and
// timestamps up to MAX_ECHO comparator echoes, with an Avalon-MM register file.
module tof_echo_timer
    import tof_pkg::*;
#(
    parameter int MAX_ECHO = 4,
    parameter int CNT_W    = 32
) (
    input  logic        avmms_clk,
    input  logic        avmms_reset,
    input  logic        laser_en,
    input  logic        comparator,
    input  logic        avmms_cs,
    input  logic        avmms_read,
    input  logic        avmms_write,
    input  logic [2:0]  avmms_address,
    input  logic [31:0] avmms_writedata,
    output logic [31:0] avmms_readdata,
    output logic        irq
);

    state_t state_reg, state_next;

    logic             laser_pulse, echo_pulse;
    logic             arm_reg, irq_en_reg, done_reg, tflag_reg;
    logic [2:0]       echo_count_reg;
    logic [CNT_W-1:0] counter_reg, timeout_reg, blank_reg;
    logic [CNT_W-1:0] echo_time [MAX_ECHO];

    logic wr_en, rd_en, ctrl_wr, abort, arm_req, arm_accept, status_clr;
    logic meas_active, capture, enter_done, timeout_hit;

    sync_edge u_laser_sync (
        .clk      (avmms_clk),
        .srst     (avmms_reset),
        .async_in (laser_en),
        .pulse    (laser_pulse)
    );

    sync_edge u_echo_sync (
        .clk      (avmms_clk),
        .srst     (avmms_reset),
        .async_in (comparator),
        .pulse    (echo_pulse)
    );

    assign wr_en      = avmms_cs & avmms_write;
    assign rd_en      = avmms_cs & avmms_read & ~avmms_write;
    assign ctrl_wr    = wr_en && (avmms_address == ADDR_CONTROL);
    assign abort      = ctrl_wr & avmms_writedata[CTRL_ABORT_BIT];
    assign arm_req    = ctrl_wr & avmms_writedata[CTRL_ARM_BIT] & ~avmms_writedata[CTRL_ABORT_BIT];
    assign arm_accept = arm_req && (state_reg == ST_IDLE);
    assign status_clr = wr_en && (avmms_address == ADDR_STATUS) && avmms_writedata[STAT_DONE_BIT];

    always_ff @(posedge avmms_clk) begin
        if (avmms_reset) state_reg <= ST_IDLE;
        else             state_reg <= state_next;
    end

    // The laser pulse cycle is itself count 0, so it is measured like MEASURE.
    always_comb begin
        state_next  = state_reg;
        meas_active = 1'b0;
        capture     = 1'b0;
        enter_done  = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_IDLE:    if (arm_accept) state_next = ST_ARMED;
            ST_ARMED:   meas_active = laser_pulse;
            ST_MEASURE: meas_active = 1'b1;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (meas_active) begin
            if (counter_reg == timeout_reg) begin
                timeout_hit = 1'b1;
                enter_done  = 1'b1;
            end else if (echo_pulse && (counter_reg >= blank_reg)) begin
                capture    = 1'b1;
                enter_done = (echo_count_reg == 3'(MAX_ECHO - 1));
            end
            state_next = enter_done ? ST_DONE : ST_MEASURE;
        end
        if (abort) begin
            state_next  = ST_IDLE;
            meas_active = 1'b0;
            capture     = 1'b0;
            enter_done  = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    always_ff @(posedge avmms_clk) begin
        if (avmms_reset) begin
            arm_reg        <= 1'b0;
            irq_en_reg     <= 1'b0;
            done_reg       <= 1'b0;
            tflag_reg      <= 1'b0;
            echo_count_reg <= '0;
            counter_reg    <= '0;
            timeout_reg    <= '0;
            blank_reg      <= '0;
        end else begin
            if (ctrl_wr) irq_en_reg <= avmms_writedata[CTRL_IRQ_EN_BIT];
            if (wr_en && avmms_address == ADDR_TIMEOUT) timeout_reg <= avmms_writedata[CNT_W-1:0];
            if (wr_en && avmms_address == ADDR_BLANK)   blank_reg   <= avmms_writedata[CNT_W-1:0];

            if (arm_accept)                arm_reg <= 1'b1;
            else if (enter_done || abort)  arm_reg <= 1'b0;

            // A hardware completion in the same cycle as a clear takes precedence.
            if (arm_accept) begin
                done_reg       <= 1'b0;
                tflag_reg      <= 1'b0;
                echo_count_reg <= '0;
            end else begin
                if (enter_done) begin
                    done_reg  <= 1'b1;
                    tflag_reg <= timeout_hit;
                end else if (status_clr) begin
                    done_reg  <= 1'b0;
                    tflag_reg <= 1'b0;
                end
                if (capture)         echo_count_reg <= echo_count_reg + 3'd1;
                else if (status_clr) echo_count_reg <= '0;
            end

            if (arm_accept || abort) counter_reg <= '0;
            else if (meas_active)    counter_reg <= (&counter_reg) ? counter_reg : counter_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < MAX_ECHO; gi++) begin : g_echo
        logic [CNT_W-1:0] time_reg;
        always_ff @(posedge avmms_clk) begin
            if (avmms_reset || arm_accept)                    time_reg <= '0;
            else if (capture && echo_count_reg == 3'(gi))     time_reg <= counter_reg;
        end
        assign echo_time[gi] = time_reg;
    end

    always_ff @(posedge avmms_clk) begin
        if (avmms_reset) begin
            avmms_readdata <= '0;
        end else if (rd_en) begin
            case (avmms_address)
                ADDR_CONTROL: avmms_readdata <= {30'd0, irq_en_reg, arm_reg};
                ADDR_STATUS:  avmms_readdata <= pack_status((state_reg == ST_ARMED) || (state_reg == ST_MEASURE),
                                                            done_reg, tflag_reg, echo_count_reg);
                ADDR_TIMEOUT: avmms_readdata <= 32'(timeout_reg);
                ADDR_BLANK:   avmms_readdata <= 32'(blank_reg);
                3'd4, 3'd5, 3'd6, 3'd7:
                              avmms_readdata <= 32'(echo_time[avmms_address[1:0]]);
                default:      avmms_readdata <= UNMAPPED_RDATA;
            endcase
        end
    end

    assign irq = done_reg & irq_en_reg;

endmodule

// File: doc/tof_echo_timer.md
TOF_ECHO_TIMER -- requirements
Module: tof_echo_timer

Interface
REQ-001 Parameter MAX_ECHO, default 4, SHALL set the number of echo timestamps captured per shot (fixed 4 for this register map).
REQ-002 Parameter CNT_W, default 32, SHALL set the time counter and timestamp width.
REQ-003 avmms_clk  in  1  sole clock; all logic SHALL be synchronous to its rising edge.
REQ-004 avmms_reset  in  1  reset, synchronous, active-high.
REQ-005 laser_en  in  1  laser strobe from the laser driver, asynchronous to avmms_clk; its rising edge is the time origin.
REQ-006 comparator  in  1  receive-path comparator, asynchronous; each rising edge is one echo.
REQ-007 avmms_cs, avmms_read, avmms_write  in  1 each  Avalon-MM slave strobes.
REQ-008 avmms_address  in  3  register select; avmms_writedata  in  32; avmms_readdata  out  32 (registered).
REQ-009 irq  out  1  level interrupt = status.done AND control.irq_en.

Function
REQ-010 laser_en and comparator SHALL each pass a 2-FF synchronizer plus rising-edge detector; equal latency on both paths, so it cancels in measurements.
REQ-011 Register map: 0 control (bit0 arm, bit1 irq_en, bit2 abort), 1 status, 2 timeout, 3 blank, 4..7 echo_time[0..3].
REQ-012 Status: bit0 busy, bit1 done, bit2 timeout_flag, bits6:4 echo_count (0..4); other bits read 0.
REQ-013 Reads SHALL return data on avmms_readdata one cycle after avmms_read&avmms_cs; unmapped addresses return 32'h89ABCDEF; write and read in the same cycle: write SHALL win and readdata holds.
REQ-014 Writing status with bit1=1 SHALL clear done, timeout_flag and echo_count (write-1-to-clear); other status bits are read-only.
REQ-015 FSM states IDLE, ARMED, MEASURE, DONE.
REQ-016 IDLE->ARMED on write of control.arm=1; echo_time[*], echo_count, done, timeout_flag SHALL be cleared on that transition.
REQ-017 ARMED->MEASURE on the first synchronized laser_en rising edge; a laser_en already high at arm SHALL NOT start (edge only); counter loads 0 on that cycle.
REQ-018 In MEASURE the counter SHALL increment by 1 per cycle and SHALL NOT wrap (saturate at all-ones).
REQ-019 Echo edge in MEASURE with counter >= blank SHALL store counter value into echo_time[echo_count] and increment echo_count; echoes with counter < blank SHALL be ignored.
REQ-020 Echo captured as the MAX_ECHO-th SHALL move MEASURE->DONE with timeout_flag=0.
REQ-021 Counter == timeout in MEASURE SHALL move to DONE with timeout_flag=1; an echo in that same cycle SHALL be discarded (timeout priority); timeout=0 times out on the start cycle.
REQ-022 Entering DONE SHALL set done=1 and clear control.arm; DONE->IDLE next cycle; done persists until cleared per REQ-014 or next arm.
REQ-023 busy SHALL be 1 in ARMED and MEASURE, else 0.
REQ-024 control.arm written while busy SHALL be ignored; control.abort=1 from any state SHALL return to IDLE without setting done; abort bit self-clears and reads 0.
REQ-025 Echo edges outside MEASURE SHALL be ignored.
REQ-026 Writes to echo_time registers SHALL be ignored.

Reset
REQ-027 Reset SHALL force IDLE; control, status, timeout, blank, counter, echo_time[*], avmms_readdata, synchronizer and edge flops SHALL be 0; irq SHALL be 0.
REQ-028 Reset asserted mid-MEASURE SHALL discard the measurement with no done/irq produced.

Structure
REQ-029 Shared package tof_pkg SHALL hold the FSM state encoding, register address constants, status bit positions and the 32'h89ABCDEF unmapped-read constant.
REQ-030 One sub-module, sync_edge (2-FF sync + rising-edge pulse), SHALL be instantiated twice.

Verification
REQ-031 timeout=1000, blank=0, arm, laser_en rises, comparator rises 200 and 450 cycles later -> timeout at count 1000; echo_time0=200, echo_time1=450, echo_count=2, timeout_flag=1, done=1.
REQ-032 blank=50, echoes at +20, +60, +70, +80, +90 -> echo_time0..3=60,70,80,90, echo_count=4, timeout_flag=0, DONE at the +90 echo.
REQ-033 irq_en=1, single echo at +100, timeout=300 -> irq rises with done; write status=0x2 -> irq=0, status=0.
REQ-034 laser_en high before arm, arm, comparator pulses -> stays ARMED, no captures; subsequent laser_en low->high starts MEASURE.
REQ-035 Echo at exactly count==timeout=500 -> discarded, timeout_flag=1, echo_count unchanged.
REQ-036 Abort mid-MEASURE, then reset mid-MEASURE on a second shot -> IDLE both times, done=0, irq=0; read address 0..7 and unmapped readback match map, write-only self-clear bits read 0.
